// File: rtl/ppt_pkg.sv
// ==== ppt_pkg: shared state encoding, default widths and prescaler clamp for the PPT sequencer.
// ==== rev 1.0
`default_nettype none

package ppt_pkg;

   localparam int unsigned DIV_W_DEF  = 5;
   localparam int unsigned TIME_W_DEF = 14;
   localparam int unsigned CNT_W_DEF  = 8;
   localparam int unsigned PRE_W_DEF  = 32;

   // Largest divider exponent; keeps 2^(div+1) inside the 32-bit prescaler.
   localparam int unsigned DIV_CLAMP  = 30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int unsigned clamp_div(input int unsigned div);
      return (div > DIV_CLAMP) ? DIV_CLAMP : div;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ppt_prescaler.sv
// ==== ppt_prescaler: one-clock tick every 2^(div+1) clocks, held at zero while clear is high.
// ==== rev 1.0
`default_nettype none

module ppt_prescaler #(
   parameter int unsigned DIV_W = 5,
   parameter int unsigned PRE_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;
   logic [PRE_W-1:0] w_terminal;

   always_comb begin
      w_terminal = (PRE_W'(1) << (div_i + DIV_W'(1))) - PRE_W'(1);
      tick_o     = !clear_i && (cnt_q == w_terminal);
      cnt_d      = (clear_i || tick_o) ? '0 : cnt_q + PRE_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ppt_pulse_gen.sv
// ==== ppt_pulse_gen: PPT firing sequencer emitting `count` pulses timed in prescaled ticks.
// ==== rev 1.0 -- define PPT_MIN_GAP_EN to force at least one low tick per period.
`default_nettype none

module ppt_pulse_gen
   import ppt_pkg::*;
#(
   parameter int unsigned DIV_W  = DIV_W_DEF,
   parameter int unsigned TIME_W = TIME_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned PRE_W  = PRE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  clk_div_i,
   input  logic [TIME_W-1:0] period_i,
   input  logic [TIME_W-1:0] width_i,
   input  logic [CNT_W-1:0]  count_i,
   input  logic              run_i,
   output logic              pulse_out_o,
   output logic [CNT_W-1:0]  count_done_o,
   output logic              done_o,
   output logic              busy_o
);

   state_t              state_q,      state_d;
   logic [DIV_W-1:0]    div_q,        div_d;
   logic [TIME_W-1:0]   period_q,     period_d;
   logic [TIME_W-1:0]   width_q,      width_d;
   logic [CNT_W-1:0]    count_q,      count_d;
   logic [TIME_W-1:0]   tick_cnt_q,   tick_cnt_d;
   logic [CNT_W-1:0]    count_done_q, count_done_d;
   logic                pulse_q,      pulse_d;

   logic [TIME_W-1:0]   w_period_eff;
   logic [TIME_W-1:0]   w_width_eff;
   logic [TIME_W-1:0]   w_tick_nxt;
   logic [CNT_W-1:0]    w_done_nxt;
   logic                w_tick;

   ppt_prescaler #(
      .DIV_W (DIV_W),
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .clear_i (state_q != ST_FIRE),
      .div_i   (div_q),
      .tick_o  (w_tick)
   );

   always_comb begin
      w_period_eff = (period_i == '0) ? TIME_W'(1) : period_i;
`ifdef PPT_MIN_GAP_EN
      w_width_eff  = (width_i < w_period_eff) ? width_i : w_period_eff - TIME_W'(1);
`else
      w_width_eff  = width_i;
`endif
   end

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      period_d     = period_q;
      width_d      = width_q;
      count_d      = count_q;
      tick_cnt_d   = tick_cnt_q;
      count_done_d = count_done_q;
      pulse_d      = pulse_q;
      w_tick_nxt   = tick_cnt_q + TIME_W'(1);
      w_done_nxt   = count_done_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            pulse_d = 1'b0;
            if (run_i) begin
               // Configuration is frozen here; later register writes have no effect.
               div_d        = DIV_W'(clamp_div(32'(clk_div_i)));
               period_d     = w_period_eff;
               width_d      = w_width_eff;
               count_d      = count_i;
               tick_cnt_d   = '0;
               count_done_d = '0;
               if (count_i == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FIRE;
                  pulse_d = (w_width_eff != '0);
               end
            end
         end
         ST_FIRE: begin
            if (!run_i) begin
               state_d = ST_IDLE;
               pulse_d = 1'b0;
            end else if (w_tick) begin
               if (tick_cnt_q == period_q - TIME_W'(1)) begin
                  tick_cnt_d   = '0;
                  count_done_d = w_done_nxt;
                  if (w_done_nxt == count_q) begin
                     state_d = ST_DONE;
                     pulse_d = 1'b0;
                  end else begin
                     pulse_d = (width_q != '0);
                  end
               end else begin
                  tick_cnt_d = w_tick_nxt;
                  pulse_d    = (w_tick_nxt < width_q);
               end
            end
         end
         ST_DONE: begin
            pulse_d = 1'b0;
            if (!run_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pulse_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         div_q        <= '0;
         period_q     <= '0;
         width_q      <= '0;
         count_q      <= '0;
         tick_cnt_q   <= '0;
         count_done_q <= '0;
         pulse_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         period_q     <= period_d;
         width_q      <= width_d;
         count_q      <= count_d;
         tick_cnt_q   <= tick_cnt_d;
         count_done_q <= count_done_d;
         pulse_q      <= pulse_d;
      end
   end

   assign pulse_out_o  = pulse_q;
   assign count_done_o = count_done_q;
   assign done_o       = (state_q == ST_DONE);
   assign busy_o       = (state_q == ST_FIRE);

endmodule

`default_nettype wire

// File: tb/tb_ppt_pulse_gen.sv
// ==== tb_ppt_pulse_gen: scoreboard bench for ppt_pulse_gen against a cycle-index waveform model.
// ==== rev 1.0
`default_nettype none

module tb_ppt_pulse_gen;

   localparam int DIV_W  = 5;
   localparam int TIME_W = 14;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DIV_W-1:0]  clk_div = '0;
   logic [TIME_W-1:0] period = '0;
   logic [TIME_W-1:0] width = '0;
   logic [CNT_W-1:0]  count = '0;
   logic              run = 1'b0;
   logic              pulse_out;
   logic [CNT_W-1:0]  count_done;
   logic              done;
   logic              busy;

   typedef struct packed {
      logic             pulse;
      logic [CNT_W-1:0] cd;
      logic             done;
      logic             busy;
   } obs_t;

   obs_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   ppt_pulse_gen dut (
      .clk          (clk),
      .rst          (rst),
      .clk_div_i    (clk_div),
      .period_i     (period),
      .width_i      (width),
      .count_i      (count),
      .run_i        (run),
      .pulse_out_o  (pulse_out),
      .count_done_o (count_done),
      .done_o       (done),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.pulse = pulse_out;
      o.cd    = count_done;
      o.done  = done;
      o.busy  = busy;
      return o;
   endfunction

   function automatic obs_t mk(logic p, int cd, logic d, logic b);
      obs_t o;
      o.pulse = p;
      o.cd    = CNT_W'(cd);
      o.done  = d;
      o.busy  = b;
      return o;
   endfunction

   task automatic check(string name, obs_t act, obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got pulse=%0b cd=%0d done=%0b busy=%0b, want pulse=%0b cd=%0d done=%0b busy=%0b",
                  name, $time, act.pulse, act.cd, act.done, act.busy,
                  exp.pulse, exp.cd, exp.done, exp.busy);
      end
   endtask

   // Reference: t = clocks since the start edge. Each period spans pe*L clocks, L = 2^(k+1).
   function automatic obs_t model(int k, int per, int wid, int cnt, int t);
      int L;
      int pe;
      int we;
      int P;
      int total;
      L  = 2 << k;
      pe = (per == 0) ? 1 : per;
      we = wid;
`ifdef PPT_MIN_GAP_EN
      if (we > pe - 1) we = pe - 1;
`endif
      P     = pe * L;
      total = cnt * P;
      if (t < total)
         return mk(((t % P) / L) < we, t / P, 1'b0, 1'b1);
      return mk(1'b0, cnt, 1'b1, 1'b0);
   endfunction

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) check("seq", sample(), exp_q.pop_front());
   end

   // mode 0: run to completion, 1: abort with run=0 at cycle a, 2: async reset at cycle a
   task automatic run_seq(int k, int per, int wid, int cnt, int mode, int a);
      int L;
      int P;
      int total;
      int n;
      L     = 2 << k;
      P     = ((per == 0) ? 1 : per) * L;
      total = cnt * P;
      if (mode != 0 && total < 2) mode = 0;
      if (mode != 0 && (a < 1 || a > total - 1)) a = total - 1;
      n = (mode == 0) ? total + 3 : a;

      @(negedge clk);
      clk_div = DIV_W'(k);
      period  = TIME_W'(per);
      width   = TIME_W'(wid);
      count   = CNT_W'(cnt);
      run     = 1'b1;
      for (int t = 0; t < n; t++) exp_q.push_back(model(k, per, wid, cnt, t));

      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            clk_div = DIV_W'($urandom);
            period  = TIME_W'($urandom);
            width   = TIME_W'($urandom);
            count   = CNT_W'($urandom);
         end
      end

      if (mode == 2) begin
         #2 rst = 1'b1;
         #1 check("rst_async", sample(), mk(1'b0, 0, 1'b0, 1'b0));
         @(negedge clk);
         run = 1'b0;
         rst = 1'b0;
         exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0));
         exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0));
      end else begin
         run = 1'b0;
         if (mode == 0) begin
            exp_q.push_back(mk(1'b0, cnt, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b0, cnt, 1'b0, 1'b0));
         end else begin
            exp_q.push_back(mk(1'b0, (a - 1) / P, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b0, (a - 1) / P, 1'b0, 1'b0));
         end
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset", sample(), mk(1'b0, 0, 1'b0, 1'b0));
      rst = 1'b0;

      run_seq(0, 4, 1, 3, 0, 0);   // 2-clk pulses every 8 clks, three firings
      run_seq(0, 4, 1, 3, 1, 9);   // abort during the second pulse
      run_seq(0, 4, 1, 3, 2, 5);   // async reset mid-sequence
      run_seq(0, 4, 1, 0, 0, 0);   // zero count goes straight to done
      run_seq(0, 4, 5, 2, 0, 0);   // width beyond period
      run_seq(1, 0, 3, 2, 0, 0);   // zero period acts as one tick
      run_seq(2, 3, 0, 2, 0, 0);   // zero width never pulses

      repeat (40) begin
         run_seq($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(0, 6),
                 $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(1, 60));
      end

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
